// File: rtl/pong_vga_pkg.sv
// Shared timing constants, playfield geometry and hit-test helpers for the
// Pong VGA renderer (640x480@60, 800x525 total).
package pong_vga_pkg;

  typedef logic [9:0]  cnt_t;
  typedef logic [11:0] coord_t;
  typedef logic [11:0] color_t;

  localparam cnt_t H_VISIBLE    = 10'd640;
  localparam cnt_t H_FRONT      = 10'd16;
  localparam cnt_t H_SYNC       = 10'd96;
  localparam cnt_t H_BACK       = 10'd48;
  localparam cnt_t H_TOTAL      = 10'd800;
  localparam cnt_t H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam cnt_t H_SYNC_END   = H_SYNC_START + H_SYNC - 10'd1;
  localparam cnt_t H_LAST       = H_TOTAL - 10'd1;

  localparam cnt_t V_VISIBLE    = 10'd480;
  localparam cnt_t V_FRONT      = 10'd10;
  localparam cnt_t V_SYNC       = 10'd2;
  localparam cnt_t V_BACK       = 10'd33;
  localparam cnt_t V_TOTAL      = 10'd525;
  localparam cnt_t V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam cnt_t V_SYNC_END   = V_SYNC_START + V_SYNC - 10'd1;
  localparam cnt_t V_LAST       = V_TOTAL - 10'd1;

  localparam coord_t P1_X_LO      = 12'd22;
  localparam coord_t P1_X_HI      = 12'd29;
  localparam coord_t P2_X_LO      = 12'd611;
  localparam coord_t P2_X_HI      = 12'd618;
  localparam coord_t WALL_TOP_LO  = 12'd22;
  localparam coord_t WALL_TOP_HI  = 12'd29;
  localparam coord_t WALL_BOT_LO  = 12'd458;
  localparam coord_t WALL_BOT_HI  = 12'd465;
  localparam coord_t NET_X_LO     = 12'd318;
  localparam coord_t NET_X_HI     = 12'd321;
  localparam coord_t NET_Y_LO     = 12'd30;
  localparam coord_t NET_Y_HI     = 12'd457;
  localparam coord_t PH_SMALL     = 12'd32;
  localparam coord_t PH_LARGE     = 12'd64;

  localparam coord_t TALLY_Y_LO   = 12'd8;
  localparam coord_t TALLY_Y_HI   = 12'd15;
  localparam coord_t TALLY_P1_X   = 12'd40;
  localparam coord_t TALLY_P2_X   = 12'd599;
  localparam coord_t TALLY_PITCH  = 12'd6;
  localparam coord_t TALLY_W      = 12'd4;

  typedef enum logic [2:0] {
    OBJ_NONE, OBJ_BALL, OBJ_PADDLE, OBJ_TALLY, OBJ_NET, OBJ_WALL
  } obj_t;

  typedef struct packed {
    logic [10:0] ball_x;
    logic [10:0] ball_y;
    logic [10:0] p1_y;
    logic [10:0] p2_y;
    logic [4:0]  p1_score;
    logic [4:0]  p2_score;
    logic        bat_size;
  } shadow_t;

  function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Sums stay 12 bits wide so objects near 2047 clip instead of wrapping.
  function automatic logic in_span(input coord_t v, input coord_t lo, input coord_t len);
    return (v >= lo) && (v < lo + len);
  endfunction

  // Player 1 bars grow rightwards from x=40, player 2 bars leftwards from x=599.
  function automatic logic tally_p1(input coord_t x, input logic [4:0] score);
    coord_t off;
    off = x - TALLY_P1_X;
    return (x >= TALLY_P1_X) && (off < coord_t'(score) * TALLY_PITCH)
           && ((off % TALLY_PITCH) < TALLY_W);
  endfunction

  function automatic logic tally_p2(input coord_t x, input logic [4:0] score);
    coord_t off;
    off = TALLY_P2_X - x;
    return (x <= TALLY_P2_X) && (off < coord_t'(score) * TALLY_PITCH)
           && ((off % TALLY_PITCH) < TALLY_W);
  endfunction

endpackage

// File: rtl/pong_vga_timing.sv
// Pixel clock-enable divider, 800x525 raster counters and raw sync/visible
// decode for the Pong renderer.
module vga_timing
  import pong_vga_pkg::*;
#(
  parameter int PIX_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en,
  output cnt_t h_cnt,
  output cnt_t v_cnt,
  output logic hsync_raw,
  output logic vsync_raw,
  output logic visible
);

  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  logic [DIV_W-1:0] div;

  assign pix_en = (div == DIV_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst)         div <= '0;
    else if (pix_en) div <= '0;
    else             div <= div + DIV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + cnt_t'(1);
      end else begin
        h_cnt <= h_cnt + cnt_t'(1);
      end
    end
  end

  assign hsync_raw = !((h_cnt >= H_SYNC_START) && (h_cnt <= H_SYNC_END));
  assign vsync_raw = !((v_cnt >= V_SYNC_START) && (v_cnt <= V_SYNC_END));
  assign visible   = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE);

endmodule

// File: rtl/pong_vga_renderer.sv
// Pong VGA renderer: latches game state at vblank start and draws the field.
// Define SCORE_TALLY_EN to draw per-point score bars along the top edge.
module pong_vga_renderer
  import pong_vga_pkg::*;
#(
  parameter int     PIX_DIV   = 4,
  parameter int     BALL_SIZE = 8,
  parameter color_t COLOR_FG  = 12'hFFF,
  parameter color_t COLOR_BG  = 12'h030
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] ball_x,
  input  logic [10:0] ball_y,
  input  logic [10:0] p1_y,
  input  logic [10:0] p2_y,
  input  logic [4:0]  p1_score,
  input  logic [4:0]  p2_score,
  input  logic        bat_size,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        video_on,
  output logic        frame_start
);

  localparam coord_t BALL_LEN = coord_t'(BALL_SIZE);

  logic    pix_en;
  cnt_t    h_cnt;
  cnt_t    v_cnt;
  logic    hsync_raw;
  logic    vsync_raw;
  logic    visible;
  logic    latch;
  shadow_t shadow;
  coord_t  x;
  coord_t  y;
  coord_t  ph;
  logic    ball_hit;
  logic    paddle_hit;
  logic    tally_hit;
  logic    net_hit;
  logic    wall_hit;
  obj_t    obj;

  vga_timing #(.PIX_DIV(PIX_DIV)) u_timing (
    .clk       (clk),
    .rst       (rst),
    .pix_en    (pix_en),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw),
    .visible   (visible)
  );

  assign latch       = pix_en && (h_cnt == '0) && (v_cnt == V_VISIBLE);
  assign frame_start = latch && !rst;

  // NOTE: shadow state is plain registers, not a memory, so it is reset
  // explicitly; frame 0 renders from all-zero positions.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
    end else if (latch) begin
      shadow <= '{ball_x: ball_x, ball_y: ball_y, p1_y: p1_y, p2_y: p2_y,
                  p1_score: p1_score, p2_score: p2_score, bat_size: bat_size};
    end
  end

  assign x  = coord_t'(h_cnt);
  assign y  = coord_t'(v_cnt);
  assign ph = shadow.bat_size ? PH_LARGE : PH_SMALL;

  assign ball_hit   = in_span(x, coord_t'(shadow.ball_x), BALL_LEN)
                   && in_span(y, coord_t'(shadow.ball_y), BALL_LEN);
  assign paddle_hit = (in_range(x, P1_X_LO, P1_X_HI) && in_span(y, coord_t'(shadow.p1_y), ph))
                   || (in_range(x, P2_X_LO, P2_X_HI) && in_span(y, coord_t'(shadow.p2_y), ph));
  assign net_hit    = in_range(x, NET_X_LO, NET_X_HI) && in_range(y, NET_Y_LO, NET_Y_HI) && !y[4];
  assign wall_hit   = in_range(y, WALL_TOP_LO, WALL_TOP_HI) || in_range(y, WALL_BOT_LO, WALL_BOT_HI);

`ifdef SCORE_TALLY_EN
  assign tally_hit = in_range(y, TALLY_Y_LO, TALLY_Y_HI)
                  && (tally_p1(x, shadow.p1_score) || tally_p2(x, shadow.p2_score));
`else
  logic unused_scores;
  assign unused_scores = ^{shadow.p1_score, shadow.p2_score};
  assign tally_hit     = 1'b0;
`endif

  // NOTE: obj gets a default before the chain so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    obj = OBJ_NONE;
    if (ball_hit)        obj = OBJ_BALL;
    else if (paddle_hit) obj = OBJ_PADDLE;
    else if (tally_hit)  obj = OBJ_TALLY;
    else if (net_hit)    obj = OBJ_NET;
    else if (wall_hit)   obj = OBJ_WALL;
  end

  // Sync and colour share one register stage so they stay pixel-aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      video_on <= 1'b0;
      rgb      <= '0;
    end else if (pix_en) begin
      hsync    <= hsync_raw;
      vsync    <= vsync_raw;
      video_on <= visible;
      if (!visible)             rgb <= '0;
      else if (obj != OBJ_NONE) rgb <= COLOR_FG;
      else                      rgb <= COLOR_BG;
    end
  end

endmodule

// File: tb/tb_pong_vga_renderer.sv
// Directed self-checking bench for pong_vga_renderer (PIX_DIV=1 main DUT,
// PIX_DIV=3 second DUT for divider timing).
module tb_pong_vga_renderer;

  localparam int F = 420000;
  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h030;
`ifdef SCORE_TALLY_EN
  localparam logic [11:0] TG = FG;
`else
  localparam logic [11:0] TG = BG;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] ball_x, ball_y, p1_y, p2_y;
  logic [4:0]  p1_score, p2_score;
  logic        bat_size;
  logic        hsync, vsync, video_on, frame_start;
  logic [11:0] rgb;
  logic        hsync3, vsync3, video_on3, frame_start3;
  logic [11:0] rgb3;

  int   k = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   hs_low = 0;
  int   vs_low = 0;
  int   fs_cnt = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  pong_vga_renderer #(.PIX_DIV(1)) dut (
    .clk(clk), .rst(rst), .ball_x(ball_x), .ball_y(ball_y), .p1_y(p1_y), .p2_y(p2_y),
    .p1_score(p1_score), .p2_score(p2_score), .bat_size(bat_size),
    .hsync(hsync), .vsync(vsync), .rgb(rgb), .video_on(video_on), .frame_start(frame_start)
  );

  pong_vga_renderer #(.PIX_DIV(3)) dut3 (
    .clk(clk), .rst(rst), .ball_x(ball_x), .ball_y(ball_y), .p1_y(p1_y), .p2_y(p2_y),
    .p1_score(p1_score), .p2_score(p2_score), .bat_size(bat_size),
    .hsync(hsync3), .vsync(vsync3), .rgb(rgb3), .video_on(video_on3), .frame_start(frame_start3)
  );

  always @(negedge clk) begin
    if (mon_en) begin
      if (!hsync)     hs_low++;
      if (!vsync)     vs_low++;
      if (frame_start) fs_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
      k += n;
    end
  endtask

  // Advance until the main DUT output shows pixel (x,y); output lags counters by one pixel.
  task automatic wait_pix(input int x, input int y);
    int target;
    int n;
    target = y * 800 + x;
    n = ((target - (k - 1)) % F + F) % F;
    step(n);
  endtask

  task automatic px(input string tag, input int x, input int y, input logic [11:0] exp);
    wait_pix(x, y);
    check(tag, rgb, exp);
  endtask

  initial begin
    ball_x = 11'd100; ball_y = 11'd200; p1_y = 11'd100; p2_y = 11'd300;
    p1_score = 5'd3; p2_score = 5'd1; bat_size = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_rgb", rgb, 0);
    check("rst_video_on", video_on, 0);
    check("rst_frame_start", frame_start, 0);
    rst = 1'b0;
    k = 0;
    mon_en = 1'b1;

    // Frame 0: shadows are zero, ball and paddles sit at the top-left.
    wait_pix(369, 2); check("div3_hsync_pre", hsync3, 1);
    wait_pix(370, 2); check("div3_hsync_fall", hsync3, 0);
    wait_pix(657, 2); check("div3_hsync_last", hsync3, 0);
    wait_pix(658, 2); check("div3_hsync_rise", hsync3, 1);
    px("f0_ball_origin", 3, 3, FG);
    px("f0_ball_right", 8, 3, BG);
    px("f0_tally_zero", 50, 10, BG);
    wait_pix(655, 10); check("hsync_655", hsync, 1);
    wait_pix(656, 10); check("hsync_656", hsync, 0);
    wait_pix(751, 10); check("hsync_751", hsync, 0);
    wait_pix(752, 10); check("hsync_752", hsync, 1);
    wait_pix(639, 20); check("video_639", video_on, 1);
    wait_pix(640, 20); check("video_640", video_on, 0);
    check("rgb_blank_640", rgb, 0);
    wait_pix(0, 479);   check("video_row479", video_on, 1);
    wait_pix(799, 479); check("f0_frame_start", frame_start, 1);
    wait_pix(0, 480);   check("frame_start_width", frame_start, 0);
    check("video_row480", video_on, 0);
    wait_pix(799, 489); check("vsync_489", vsync, 1);
    wait_pix(0, 490);   check("vsync_490", vsync, 0);
    wait_pix(799, 491); check("vsync_491", vsync, 0);
    wait_pix(0, 492);   check("vsync_492", vsync, 1);
    wait_pix(799, 524);
    mon_en = 1'b0;
    check("hsync_low_per_frame", hs_low, 96 * 525);
    check("vsync_low_per_frame", vs_low, 2 * 800);
    check("frame_start_count", fs_cnt, 1);

    // Frame 1: latched ball (100,200), paddles 100/300 small, scores 3/1.
    px("t_p1_bar0_l", 40, 10, TG);
    px("t_p1_bar0_r", 43, 10, TG);
    px("t_p1_gap", 44, 10, BG);
    px("t_p1_bar1", 46, 10, TG);
    px("t_p1_bar2_l", 52, 10, TG);
    px("t_p1_bar2_r", 55, 10, TG);
    px("t_p1_bar3_absent", 58, 10, BG);
    px("t_p2_left_out", 595, 10, BG);
    px("t_p2_bar0_l", 596, 10, TG);
    px("t_p2_bar0_r", 599, 10, TG);
    px("t_p2_right_out", 600, 10, BG);
    px("wall_top_21", 200, 21, BG);
    px("wall_top_22", 200, 22, FG);
    px("wall_top_29", 200, 29, FG);
    px("wall_top_30", 200, 30, BG);
    px("net_left_out", 317, 32, BG);
    px("net_dash_on", 318, 32, FG);
    px("net_right_on", 321, 40, FG);
    px("net_dash_off", 318, 48, BG);
    px("p1_above", 25, 99, BG);
    px("p1_top", 25, 100, FG);
    wait_pix(0, 110);
    ball_x = 11'd300; ball_y = 11'd50; p1_y = 11'd20; bat_size = 1'b1;
    px("p1_right_out", 30, 120, BG);
    px("p1_small_last", 22, 131, FG);
    px("p1_small_held", 25, 132, BG);
    px("ball_above", 100, 199, BG);
    px("ball_x99", 99, 200, BG);
    px("ball_x100", 100, 200, FG);
    px("ball_x107", 107, 200, FG);
    px("ball_x108", 108, 200, BG);
    px("ball_new_x_hidden", 300, 200, BG);
    px("ball_bottom", 100, 207, FG);
    px("ball_below", 100, 208, BG);
    px("p2_top", 611, 300, FG);
    px("p2_right_out", 619, 300, BG);
    px("p2_last", 618, 331, FG);
    px("p2_below", 618, 332, BG);
    px("wall_bot_457", 200, 457, BG);
    px("wall_bot_458", 200, 458, FG);
    px("wall_bot_465", 200, 465, FG);
    px("wall_bot_466", 200, 466, BG);
    wait_pix(799, 479); check("f1_frame_start", frame_start, 1);

    // Frame 2: ball (300,50), large paddle from y=20.
    px("f2_p1_above", 25, 19, BG);
    px("f2_p1_top", 25, 20, FG);
    px("f2_old_ball_x", 100, 50, BG);
    px("f2_ball_x299", 299, 50, BG);
    px("f2_ball_x300", 300, 50, FG);
    px("f2_ball_x308", 308, 50, BG);
    px("f2_ball_corner", 307, 57, FG);
    px("f2_p1_large_last", 25, 83, FG);
    px("f2_p1_large_below", 25, 84, BG);

    // Reset for one clk while counters sit at (300,100).
    px("pre_reset_bg", 299, 100, BG);
    rst = 1'b1;
    step(1);
    check("mid_rst_h_cnt", dut.u_timing.h_cnt, 0);
    check("mid_rst_v_cnt", dut.u_timing.v_cnt, 0);
    check("mid_rst_hsync", hsync, 1);
    check("mid_rst_vsync", vsync, 1);
    check("mid_rst_rgb", rgb, 0);
    check("mid_rst_video_on", video_on, 0);
    rst = 1'b0;
    k = 0;
    wait_pix(656, 0); check("resume_hsync", hsync, 0);
    px("resume_ball_origin", 3, 3, FG);
    px("resume_ball_right", 8, 3, BG);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
